// File: rtl/arb_rr4_ctrl_if.sv
// rtl/arb_rr4_ctrl_if.sv - request/grant bundle between four clients and the arbiter
//
// Purpose: groups the client-side request lines, mode/done controls and the
//          arbiter's grant/status outputs into one bundle.
// Signals:
//   req[3:0]     client request lines, one per client
//   mode         0 = round-robin, 1 = fixed priority (index 3 highest)
//   done         completion pulse from the shared resource for the current owner
//   gnt[3:0]     one-hot grant, zero when no owner
//   gnt_id[1:0]  binary index of the owner, valid while gnt_valid is high
//   gnt_valid    high whenever gnt is non-zero
//   timeout      one-cycle pulse when the hold limit revokes a grant
//   busy         high while a grant is active or in the turnaround cycle
// Modports:
//   master  client/resource side (drives req, mode, done)
//   slave   arbiter side (drives gnt, gnt_id, gnt_valid, timeout, busy)

interface arb_rr4_ctrl_if;
    logic [3:0] req;
    logic       mode;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       busy;

    modport master (
        output req, mode, done,
        input  gnt, gnt_id, gnt_valid, timeout, busy
    );

    modport slave (
        input  req, mode, done,
        output gnt, gnt_id, gnt_valid, timeout, busy
    );
endinterface

// File: rtl/arb_rr4_ctrl.sv
// rtl/arb_rr4_ctrl.sv - four-requester arbiter with round-robin/fixed priority and hold limit
//
// Purpose: grants exclusive ownership of one shared resource to one of four
//          clients. The grant is held until done, until the owner drops its
//          request, or until MAX_HOLD cycles have elapsed.
// Parameters:
//   MAX_HOLD  maximum cycles a grant may be held (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    arb_rr4_ctrl_if.slave: req/mode/done in, gnt/gnt_id/gnt_valid/timeout/busy out

module arb_rr4_ctrl #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arb_rr4_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0]       fix_win;
    logic [1:0]       rr_win;
    logic             rr_found;
    logic [1:0]       win;
    logic             rel_done;
    logic             rel_abandon;
    logic             rel_limit;

    // Fixed priority: later (higher) indices overwrite earlier ones, so the
    // highest set bit wins.
    always_comb begin
        fix_win = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (bus.req[k]) begin
                fix_win = 2'(k);
            end
        end
    end

    // Round-robin: scan ptr, ptr+1, ... with 2-bit wraparound; first hit wins.
    always_comb begin
        rr_win   = ptr_q;
        rr_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!rr_found && bus.req[ptr_q + 2'(k)]) begin
                rr_win   = ptr_q + 2'(k);
                rr_found = 1'b1;
            end
        end
    end

    assign win = bus.mode ? fix_win : rr_win;

    // Release causes, evaluated in priority order: done, then abandon, then limit.
    assign rel_done    = bus.done;
    assign rel_abandon = !bus.req[gnt_id_q];
    assign rel_limit   = (hold_cnt_q == HOLD_LIMIT);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_d     = ST_BUSY;
                    gnt_d       = 4'b0001 << win;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_ONE;
                end
            end
            ST_BUSY: begin
                if (rel_done || rel_abandon || rel_limit) begin
                    state_d     = ST_REL;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    ptr_d       = gnt_id_q + 2'd1;
                    // Only flag a timeout when neither higher-priority cause applies.
                    timeout_d   = !rel_done && !rel_abandon;
                end else if (hold_cnt_q < HOLD_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// tb/tb_arb_rr4_ctrl.sv - directed self-checking bench for arb_rr4_ctrl

module tb_arb_rr4_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    arb_rr4_ctrl_if bus ();

    arb_rr4_ctrl #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant must be one-hot or zero and gnt_valid must track it, every cycle.
    always @(negedge clk) begin
        check("inv_onehot", 8'($onehot0(bus.gnt)), 8'd1);
        check("inv_valid", 8'(bus.gnt_valid), 8'(|bus.gnt));
    end

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.mode = 1'b0;
        bus.done = 1'b0;

        // Reset held two edges with all requests active: nothing granted.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_gnt", 8'(bus.gnt), 8'h00);
            check("rst_vld", 8'(bus.gnt_valid), 8'h00);
            check("rst_busy", 8'(bus.busy), 8'h00);
            check("rst_tmo", 8'(bus.timeout), 8'h00);
        end
        rst_n = 1'b1;
        tick();
        check("first_gnt", 8'(bus.gnt), 8'h01);
        check("first_id", 8'(bus.gnt_id), 8'h00);
        check("first_busy", 8'(bus.busy), 8'h01);

        // Round-robin rotation 0,1,2,3,0 with a REL and an IDLE cycle between grants.
        for (int i = 1; i < 5; i++) begin
            bus.done = 1'b1;
            tick();
            check("rr_rel_gnt", 8'(bus.gnt), 8'h00);
            check("rr_rel_busy", 8'(bus.busy), 8'h01);
            check("rr_rel_tmo", 8'(bus.timeout), 8'h00);
            bus.done = 1'b0;
            tick();
            check("rr_idle_gnt", 8'(bus.gnt), 8'h00);
            check("rr_idle_busy", 8'(bus.busy), 8'h00);
            tick();
            check("rr_gnt", 8'(bus.gnt), 8'(4'b0001 << exp_order[i]));
            check("rr_id", 8'(bus.gnt_id), 8'(exp_order[i]));
        end

        // Fixed priority: 0110 -> client 2, then 0011 -> client 1.
        bus.mode = 1'b1;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 4'b0110;
        tick();
        tick();
        check("fix_gnt", 8'(bus.gnt), 8'h04);
        check("fix_id", 8'(bus.gnt_id), 8'h02);
        bus.done = 1'b1;
        bus.req  = 4'b0011;
        tick();
        check("fix_rel", 8'(bus.gnt), 8'h00);
        bus.done = 1'b0;
        tick();
        tick();
        check("fix_gnt2", 8'(bus.gnt), 8'h02);
        check("fix_id2", 8'(bus.gnt_id), 8'h01);

        // Abandon release of client 1 (ptr -> 2), then timeout scenario on client 0.
        bus.req = 4'b0000;
        tick();
        check("aban1_gnt", 8'(bus.gnt), 8'h00);
        check("aban1_tmo", 8'(bus.timeout), 8'h00);
        bus.mode = 1'b0;
        bus.req  = 4'b0001;
        tick();
        tick();
        check("to_gnt0", 8'(bus.gnt), 8'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_hold", 8'(bus.gnt), 8'h01);
            check("to_hold_tmo", 8'(bus.timeout), 8'h00);
        end
        tick();
        check("to_rev_gnt", 8'(bus.gnt), 8'h00);
        check("to_pulse", 8'(bus.timeout), 8'h01);
        check("to_busy", 8'(bus.busy), 8'h01);
        tick();
        check("to_idle_tmo", 8'(bus.timeout), 8'h00);
        check("to_idle_gnt", 8'(bus.gnt), 8'h00);
        tick();
        check("to_regnt", 8'(bus.gnt), 8'h01);

        // Move ownership to client 3 (ptr becomes 1 after releasing 0).
        bus.done = 1'b1;
        bus.req  = 4'b1000;
        tick();
        bus.done = 1'b0;
        tick();
        tick();
        check("wrap_gnt3", 8'(bus.gnt), 8'h08);
        check("wrap_id3", 8'(bus.gnt_id), 8'h03);
        // Mode change mid-BUSY must not disturb the grant.
        bus.mode = 1'b1;
        tick();
        check("wrap_mode_hold", 8'(bus.gnt), 8'h08);
        bus.mode = 1'b0;
        bus.req  = 4'b0000;
        tick();
        check("wrap_rel_gnt", 8'(bus.gnt), 8'h00);
        check("wrap_rel_tmo", 8'(bus.timeout), 8'h00);
        bus.req = 4'b1001;
        tick();
        tick();
        check("wrap_gnt0", 8'(bus.gnt), 8'h01);

        // done coincident with hold_cnt == MAX_HOLD: normal release, no timeout.
        tick();
        tick();
        tick();
        check("lim_hold", 8'(bus.gnt), 8'h01);
        bus.done = 1'b1;
        tick();
        check("lim_rel_gnt", 8'(bus.gnt), 8'h00);
        check("lim_rel_tmo", 8'(bus.timeout), 8'h00);
        bus.done = 1'b0;

        // Reset mid-BUSY while client 2 owns; ptr after releasing 0 is 1.
        bus.req = 4'b0100;
        tick();
        tick();
        check("mr_gnt2", 8'(bus.gnt), 8'h04);
        rst_n = 1'b0;
        tick();
        check("mr_gnt", 8'(bus.gnt), 8'h00);
        check("mr_busy", 8'(bus.busy), 8'h00);
        check("mr_id", 8'(bus.gnt_id), 8'h00);
        rst_n   = 1'b1;
        bus.req = 4'b0101;
        tick();
        check("mr_regnt", 8'(bus.gnt), 8'h01);
        check("mr_regnt_id", 8'(bus.gnt_id), 8'h00);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
